// File: rtl/regfile_wb_pkg.sv
// Shared widths, the write-back FIFO entry type and a one-hot helper for the
// register-file write-back unit.
package regfile_wb_pkg;
    localparam int REG_ADDR_W    = 5;
    localparam int INST_W        = 32;
    localparam int REG_NUM       = 32;
    localparam int WB_FIFO_DEPTH = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [INST_W-1:0]     inst_t;

    localparam inst_t ZERO_WORD = '0;

    typedef struct packed {
        reg_addr_t rd;
        inst_t     data;
    } wb_ent_t;

    function automatic logic [REG_NUM-1:0] reg_onehot(input reg_addr_t r);
        return REG_NUM'(1) << r;
    endfunction
endpackage

// File: rtl/regfile_wb_if.sv
// Execute-side and register-file-side signals of the write-back unit.
// master = producers/issue/register file, slave = regfile_wb.
interface regfile_wb_if;
    import regfile_wb_pkg::*;

    logic               alu_valid;
    reg_addr_t          alu_rd;
    inst_t              alu_data;
    logic               ml_valid;
    logic               ml_ready;
    reg_addr_t          ml_rd;
    inst_t              ml_data;
    logic               issue_valid;
    logic               issue_long;
    reg_addr_t          issue_rd;
    logic [REG_NUM-1:0] busy;
    logic               wen;
    reg_addr_t          rd_waddr;
    inst_t              rd_wdata;

    modport master (
        output alu_valid, alu_rd, alu_data, ml_valid, ml_rd, ml_data,
               issue_valid, issue_long, issue_rd,
        input  ml_ready, busy, wen, rd_waddr, rd_wdata
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, ml_valid, ml_rd, ml_data,
               issue_valid, issue_long, issue_rd,
        output ml_ready, busy, wen, rd_waddr, rd_wdata
    );
endinterface

// File: rtl/regfile_wb_fifo.sv
// Synchronous FIFO for long-latency results. DEPTH must be a power of two so
// the pointers wrap naturally; callers never push when full or pop when empty.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/regfile_wb.sv
// Write-back arbiter: ALU results take priority over queued long-latency
// results; a scoreboard tracks registers with outstanding long-latency writes.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rstn,
    regfile_wb_if.slave  bus
);
    wb_ent_t            ml_ent, head;
    logic               fifo_full, fifo_empty, push, pop;
    logic               wen_q, wen_d, wb_long_q, wb_long_d;
    reg_addr_t          rd_waddr_q, rd_waddr_d;
    inst_t              rd_wdata_q, rd_wdata_d;
    logic [REG_NUM-1:0] busy_q, busy_d, commit_clr, issue_set, busy_eff;

    assign ml_ent = '{rd: bus.ml_rd, data: bus.ml_data};
    assign push   = bus.ml_valid & ~fifo_full;
    assign pop    = ~bus.alu_valid & ~fifo_empty;

    wb_fifo #(.W($bits(wb_ent_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (ml_ent),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        wen_d      = 1'b0;
        wb_long_d  = 1'b0;
        rd_waddr_d = rd_waddr_q;
        rd_wdata_d = rd_wdata_q;
        if (bus.alu_valid) begin
            wen_d      = (bus.alu_rd != '0);
            rd_waddr_d = bus.alu_rd;
            rd_wdata_d = bus.alu_data;
        end else if (!fifo_empty) begin
            wen_d      = (head.rd != '0);
            wb_long_d  = 1'b1;
            rd_waddr_d = head.rd;
            rd_wdata_d = head.data;
        end

        // Set is applied after clear so a same-edge re-issue keeps the bit.
        commit_clr = (wen_q & wb_long_q) ? reg_onehot(rd_waddr_q) : '0;
        issue_set  = (bus.issue_valid & bus.issue_long) ? reg_onehot(bus.issue_rd) : '0;
        busy_d     = (busy_q & ~commit_clr) | issue_set;
        busy_d[0]  = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wen_q      <= 1'b0;
            wb_long_q  <= 1'b0;
            rd_waddr_q <= '0;
            rd_wdata_q <= ZERO_WORD;
            busy_q     <= '0;
        end else begin
            wen_q      <= wen_d;
            wb_long_q  <= wb_long_d;
            rd_waddr_q <= rd_waddr_d;
            rd_wdata_q <= rd_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ml_ready = ~fifo_full;
    assign bus.busy     = busy_q;
    assign bus.wen      = wen_q;
    assign bus.rd_waddr = rd_waddr_q;
    assign bus.rd_wdata = rd_wdata_q;

    // A register whose write commits at this edge is no longer a hazard.
    assign busy_eff = busy_q & ~commit_clr;

    a_no_busy_issue: assert property (@(posedge clk) disable iff (!rstn)
        !(bus.issue_valid && busy_eff[bus.issue_rd]));
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb with a queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    regfile_wb_if bus();

    regfile_wb #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a queue of pending long results and a busy bit vector.
    wb_ent_t     m_q[$];
    bit          m_wen  = 1'b0;
    bit          m_long = 1'b0;
    reg_addr_t   m_waddr = '0;
    inst_t       m_wdata = '0;
    logic [31:0] m_busy = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q.delete();
            m_wen  <= 1'b0;
            m_long <= 1'b0;
            m_busy <= '0;
        end else begin
            automatic logic [31:0] nb  = m_busy;
            automatic bit          acc = bus.ml_valid && (m_q.size() < DEPTH);
            automatic wb_ent_t     h;
            if (m_wen && m_long) nb[m_waddr] = 1'b0;
            if (bus.issue_valid && bus.issue_long && bus.issue_rd != 0) nb[bus.issue_rd] = 1'b1;
            m_busy <= nb;
            if (bus.alu_valid) begin
                m_wen   <= (bus.alu_rd != 0);
                m_long  <= 1'b0;
                m_waddr <= bus.alu_rd;
                m_wdata <= bus.alu_data;
            end else if (m_q.size() > 0) begin
                h = m_q.pop_front();
                m_wen   <= (h.rd != 0);
                m_long  <= 1'b1;
                m_waddr <= h.rd;
                m_wdata <= h.data;
            end else begin
                m_wen  <= 1'b0;
                m_long <= 1'b0;
            end
            if (acc) m_q.push_back('{rd: bus.ml_rd, data: bus.ml_data});
        end
    end

    // Per-cycle comparison against the model, plus a log of committed writes.
    wb_ent_t wlog[$];
    always @(negedge clk) begin
        chk("model_wen", bus.wen, m_wen);
        chk("model_ready", bus.ml_ready, (m_q.size() < DEPTH));
        chk("model_busy", bus.busy, m_busy);
        if (m_wen) begin
            chk("model_waddr", bus.rd_waddr, m_waddr);
            chk("model_wdata", bus.rd_wdata, m_wdata);
        end
        if (rstn && bus.wen) wlog.push_back('{rd: bus.rd_waddr, data: bus.rd_wdata});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.ml_valid    = 1'b0;
        bus.ml_rd       = '0;
        bus.ml_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_long  = 1'b0;
        bus.issue_rd    = '0;
    endtask

    task automatic issue_long(input reg_addr_t rd);
        bus.issue_valid = 1'b1;
        bus.issue_long  = 1'b1;
        bus.issue_rd    = rd;
    endtask

    task automatic offer_ml(input reg_addr_t rd, input inst_t d);
        bus.ml_valid = 1'b1;
        bus.ml_rd    = rd;
        bus.ml_data  = d;
    endtask

    initial begin
        idle();
        repeat (2) tick();
        chk("rst_wen", bus.wen, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.ml_ready, 1);
        chk("rst_waddr", bus.rd_waddr, 0);
        chk("rst_wdata", bus.rd_wdata, 0);
        rstn = 1'b1;
        tick();

        // ALU only
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
        tick();
        idle();
        chk("alu_wen", bus.wen, 1);
        chk("alu_waddr", bus.rd_waddr, 5);
        chk("alu_wdata", bus.rd_wdata, 32'h1234);
        chk("alu_busy", bus.busy, 0);
        tick();
        chk("alu_wen_off", bus.wen, 0);

        // Long path
        issue_long(5'd7);
        tick();
        idle();
        chk("long_busy_set", bus.busy, 32'h80);
        repeat (2) tick();
        chk("long_ready", bus.ml_ready, 1);
        offer_ml(5'd7, 32'hDEADBEEF);
        tick();
        idle();
        chk("long_pop_cycle_wen", bus.wen, 0);
        tick();
        chk("long_wen", bus.wen, 1);
        chk("long_waddr", bus.rd_waddr, 7);
        chk("long_wdata", bus.rd_wdata, 32'hDEADBEEF);
        chk("long_busy_still", bus.busy, 32'h80);
        tick();
        chk("long_busy_clr", bus.busy, 0);

        // Contention: 4 ALU results and 3 long results competing
        wlog.delete();
        begin
            int k = 0;
            int cyc = 0;
            bit acc;
            while ((k < 3 || cyc < 4) && cyc < 20) begin
                bus.alu_valid = (cyc < 4);
                bus.alu_rd    = 5'(10 + cyc);
                bus.alu_data  = 32'hA0 + 32'(cyc);
                bus.ml_valid  = (k < 3);
                bus.ml_rd     = 5'(14 + k);
                bus.ml_data   = 32'hB0 + 32'(k);
                acc = bus.ml_valid && bus.ml_ready;
                if (cyc == 2) chk("cont_ready_full", bus.ml_ready, 0);
                tick();
                if (acc) k++;
                cyc++;
            end
            chk("cont_all_accepted", k, 3);
        end
        idle();
        repeat (4) tick();
        chk("cont_writes", wlog.size(), 7);
        for (int i = 0; i < 7 && i < wlog.size(); i++) begin
            chk("cont_rd", wlog[i].rd, (i < 4) ? 10 + i : 14 + (i - 4));
            chk("cont_data", wlog[i].data, (i < 4) ? 32'hA0 + i : 32'hB0 + (i - 4));
        end

        // Same-edge set and clear of x9
        issue_long(5'd9);
        tick();
        idle();
        offer_ml(5'd9, 32'h99);
        tick();
        idle();
        tick();
        chk("same_wen", bus.wen, 1);
        chk("same_waddr", bus.rd_waddr, 9);
        issue_long(5'd9);
        tick();
        idle();
        chk("same_busy_kept", bus.busy, 32'h200);
        offer_ml(5'd9, 32'h100);
        tick();
        idle();
        repeat (3) tick();
        chk("same_busy_clr", bus.busy, 0);

        // x0 destination
        wlog.delete();
        offer_ml(5'd0, 32'h55);
        tick();
        idle();
        chk("x0_queued_ready", bus.ml_ready, 1);
        repeat (2) tick();
        chk("x0_wen", bus.wen, 0);
        chk("x0_busy", bus.busy, 0);
        chk("x0_nolog", wlog.size(), 0);
        issue_long(5'd0);
        tick();
        idle();
        chk("x0_busy0", bus.busy, 0);

        // Reset in the middle of traffic with a full FIFO
        issue_long(5'd3);
        tick();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
        offer_ml(5'd3, 32'h33);
        tick();
        offer_ml(5'd4, 32'h44);
        tick();
        chk("mid_full", bus.ml_ready, 0);
        chk("mid_busy", bus.busy, 32'h8);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_wen", bus.wen, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.ml_ready, 1);
        idle();
        tick();
        rstn = 1'b1;
        wlog.delete();
        repeat (3) tick();
        chk("post_rst_nowrites", wlog.size(), 0);
        chk("post_rst_wen", bus.wen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
